cskip_sub_seq: RTL and testbench

- Block-serial subtractor computing d = a - b - bin over WIDTH bits, one BLOCK-bit segment per clock.
- The borrow chain is carried in a register between segments.
- Each segment's group-propagate (skip) condition is recorded and reported.
- Counterpart to the combinational carry-skip adders: the area-lean subtract direction for multi-cycle datapaths that check or undo adder results. Uses valid/ready handshakes on both sides.

---
 rtl/cskip_sub_seq.sv | 168 ++++++++++++++++
 tb/tb_cskip_sub_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cskip_sub_seq.sv
// cskip_sub_seq
//   Block-serial subtractor: d = a - b - bin (mod 2^WIDTH), one BLOCK-bit
//   segment per clock. The borrow chain is held as an inverted carry c
//   (a + ~b + ~bin) between segments, and each segment's skip
//   (group-propagate) condition is recorded in blk_skip.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   d          difference a - b - bin, modulo 2^WIDTH
//   bout       borrow out, 1 iff a < b + bin (unsigned)
//   blk_skip   bit i = 1 iff segment i of (a XNOR b) is all ones
module cskip_sub_seq #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         d,
  output logic                     bout,
  output logic [WIDTH/BLOCK-1:0]   blk_skip
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c;
  logic [IW-1:0]    idx;

  logic [BLOCK-1:0] seg_a;
  logic [BLOCK-1:0] seg_nb;
  logic [BLOCK-1:0] seg_p;
  logic [BLOCK-1:0] seg_g;
  logic [BLOCK-1:0] seg_sum;
  logic             seg_skip;
  logic             ripple_c;
  logic             c_out;
  logic             last_seg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign last_seg = (idx == IW'(NBLK - 1));

  // Next-state and handshake decode
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (last_seg) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Segment select from the latched operands
  always_comb begin
    seg_a  = '0;
    seg_nb = '0;
    for (int unsigned i = 0; i < NBLK; i++) begin
      if (idx == IW'(i)) begin
        seg_a  = a_r[i*BLOCK +: BLOCK];
        seg_nb = ~b_r[i*BLOCK +: BLOCK];
      end
    end
  end

  // Segment adder: ripple generate/propagate for sum and carry; the skip
  // path forwards c directly when every bit propagates, which yields the
  // same carry as the ripple result.
  always_comb begin
    seg_p    = seg_a ^ seg_nb;
    seg_g    = seg_a & seg_nb;
    seg_sum  = '0;
    ripple_c = c;
    for (int unsigned j = 0; j < BLOCK; j++) begin
      seg_sum[j] = seg_p[j] ^ ripple_c;
      ripple_c   = seg_g[j] | (seg_p[j] & ripple_c);
    end
    seg_skip = &seg_p;
    c_out    = seg_skip ? c : ripple_c;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      c        <= 1'b0;
      idx      <= '0;
      d        <= '0;
      bout     <= 1'b0;
      blk_skip <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            c   <= ~bin;
            idx <= '0;
          end
        end
        BUSY: begin
          for (int unsigned i = 0; i < NBLK; i++) begin
            if (idx == IW'(i)) begin
              d[i*BLOCK +: BLOCK] <= seg_sum;
              blk_skip[i]         <= seg_skip;
            end
          end
          c <= c_out;
          if (last_seg) begin
            bout <= ~c_out;
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cskip_sub_seq.sv
module tb_cskip_sub_seq;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int NBLK  = WIDTH / BLOCK;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              bin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  d;
  logic              bout;
  logic [NBLK-1:0]   blk_skip;

  int total = 0;
  int bad   = 0;

  cskip_sub_seq #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .blk_skip  (blk_skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic and segment equality.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                       output logic [WIDTH-1:0] ed, output logic eb, output logic [NBLK-1:0] es);
    logic [WIDTH:0] diff;
    diff = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    ed = diff[WIDTH-1:0];
    eb = diff[WIDTH];
    for (int i = 0; i < NBLK; i++) begin
      es[i] = (ma[i*BLOCK +: BLOCK] == mb[i*BLOCK +: BLOCK]);
    end
  endtask

  // Issue one operation, check latency and results; leaves the DUT in DONE.
  task automatic issue(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin);
    logic [WIDTH-1:0] ed;
    logic             eb;
    logic [NBLK-1:0]  es;
    int               n;
    model(oa, ob, obin, ed, eb, es);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(NBLK));
    check("d", 64'(d), 64'(ed));
    check("bout", 64'(bout), 64'(eb));
    check("blk_skip", 64'(blk_skip), 64'(es));
    check("in_ready_done", 64'(in_ready), 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_drain", 64'(out_valid), 64'd0);
    check("in_ready_after_drain", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] hd, ra, rb;
    logic             hb;
    logic [NBLK-1:0]  hs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_d", 64'(d), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_blk_skip", 64'(blk_skip), 64'd0);

    issue(32'd5, 32'd3, 1'b0);
    check("plan1_d", 64'(d), 64'h2);
    check("plan1_skip", 64'(blk_skip), 64'b1110);
    drain();

    issue(32'd0, 32'd1, 1'b0);
    check("plan2_d", 64'(d), 64'hFFFF_FFFF);
    check("plan2_bout", 64'(bout), 64'd1);
    drain();

    issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    check("plan3_skip", 64'(blk_skip), 64'b1111);
    check("plan3_bout", 64'(bout), 64'd1);
    drain();

    // Hold: out_ready low, new operands offered; nothing may change.
    issue(32'h8000_0000, 32'd1, 1'b0);
    hd = d; hb = bout; hs = blk_skip;
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0001; bin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_d", 64'(d), 64'(hd));
      check("hold_bout", 64'(bout), 64'(hb));
      check("hold_skip", 64'(blk_skip), 64'(hs));
    end
    in_valid = 1'b0;
    drain();

    // Reset in the 2nd BUSY cycle discards the operation.
    a = 32'hFFFF_0000; b = 32'h0000_FFFF; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    check("midrst_bout", 64'(bout), 64'd0);
    check("midrst_skip", 64'(blk_skip), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    // in_valid together with rst must not be accepted.
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_valid_not_accepted", 64'(in_ready), 64'd1);
    tick();
    check("still_idle", 64'(out_valid), 64'd0);

    issue(32'd10, 32'd10, 1'b0);
    check("post_rst_d", 64'(d), 64'd0);
    check("post_rst_skip", 64'(blk_skip), 64'b1111);
    drain();

    // Random operations, some with copied segments to exercise skips.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      for (int s = 0; s < NBLK; s++) begin
        if ($urandom_range(0, 1) == 1) rb[s*BLOCK +: BLOCK] = ra[s*BLOCK +: BLOCK];
      end
      issue(ra, rb, 1'($urandom));
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
